// File: rtl/etc1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : etc1_pkg
// Brief    : Shared types, field positions, modifier table and colour
//            expansion helpers for the ETC1 block decoder.
// Revision : 1.0 - initial release
// ============================================================================
package etc1_pkg;

    // Decoded texel, packed so that {r, g, b} lines up with RGB888 [23:0]
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Colour byte positions inside the 64-bit block (MSB of each byte).
    // Each byte carries both sub-block colours for one channel.
    localparam int COLOR_R_MSB   = 63;
    localparam int COLOR_G_MSB   = 55;
    localparam int COLOR_B_MSB   = 47;
    localparam int COLOR_STRIDE  = 8;

    // Control word fields
    localparam int TABLE0_LSB    = 37;
    localparam int TABLE1_LSB    = 34;
    localparam int DIFF_BIT      = 33;
    localparam int FLIP_BIT      = 32;

    // Per-texel index planes (16 bits each, bit n belongs to texel n)
    localparam int IDX_MSB_BASE  = 16;
    localparam int IDX_LSB_BASE  = 0;
    localparam int IDX_PLANE_W   = 16;

    localparam int NUM_CHANNELS  = 3;
    localparam int NUM_TABLES    = 8;

    // Modifier magnitudes: [table][0] is the small step a, [table][1] the
    // large step b. The sign comes from the upper index bit.
    localparam logic [7:0] MOD_TABLE [NUM_TABLES][2] = '{
        '{8'd2,  8'd8  },
        '{8'd5,  8'd17 },
        '{8'd9,  8'd29 },
        '{8'd13, 8'd42 },
        '{8'd18, 8'd60 },
        '{8'd24, 8'd80 },
        '{8'd33, 8'd106},
        '{8'd47, 8'd183}
    };

    // 4-bit colour to 8 bits by nibble replication
    function automatic logic [7:0] expand4(input logic [3:0] v);
        return {v, v};
    endfunction

    // 5-bit colour to 8 bits by replicating the top three bits into the LSBs
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

endpackage : etc1_pkg
`default_nettype wire

// File: rtl/etc1_channel.sv
`default_nettype none
// ============================================================================
// Module   : etc1_channel
// Brief    : One colour channel of the ETC1 decode: adds a signed modifier
//            to an 8-bit expanded base colour and clamps to 0..255.
// Revision : 1.0 - initial release
// ============================================================================
module etc1_channel (
    input  logic              [7:0] i_base,
    input  logic signed       [8:0] i_mod,
    output logic              [7:0] o_value
);

    // 10 bits holds 0..255 plus +/-183 with a spare sign bit, so the sum
    // can never wrap before the clamp looks at it.
    logic signed [9:0] w_sum;

    assign w_sum = $signed({2'b00, i_base}) + $signed({i_mod[8], i_mod});

    // Clamp: negative -> 0, above 255 (bit 8 set while non-negative) -> 255
    always_comb begin
        o_value = w_sum[7:0];
        if (w_sum[9]) begin
            o_value = 8'h00;
        end else if (w_sum[8]) begin
            o_value = 8'hFF;
        end
    end

endmodule : etc1_channel
`default_nettype wire

// File: rtl/etc1_decode.sv
`default_nettype none
// ============================================================================
// Module   : etc1_decode
// Brief    : Decodes one texel (x, y) of a 64-bit ETC1 block to RGB888 with
//            a single registered output stage. No handshake; one texel per
//            clock; asynchronous active-low reset clears the output.
// Revision : 1.0 - initial release
// ============================================================================
module etc1_decode
    import etc1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] block,
    input  logic [1:0]  x,
    input  logic [1:0]  y,
    output logic [23:0] pixel
);

    // ------------------------------------------------------------------
    // Control fields
    // ------------------------------------------------------------------
    logic        w_diff;
    logic        w_flip;
    logic [2:0]  w_table0;
    logic [2:0]  w_table1;

    assign w_diff   = block[DIFF_BIT];
    assign w_flip   = block[FLIP_BIT];
    assign w_table0 = block[TABLE0_LSB +: 3];
    assign w_table1 = block[TABLE1_LSB +: 3];

    // ------------------------------------------------------------------
    // Sub-block selection and per-texel index
    // ------------------------------------------------------------------
    logic        w_sub1;
    logic [2:0]  w_table_sel;
    logic [3:0]  w_texel_n;
    logic [15:0] w_idx_msbs;
    logic [15:0] w_idx_lsbs;
    logic [1:0]  w_idx;

    assign w_idx_msbs = block[IDX_MSB_BASE +: IDX_PLANE_W];
    assign w_idx_lsbs = block[IDX_LSB_BASE +: IDX_PLANE_W];

    // Column-major texel number x*4+y, sub-block split along x or y
    always_comb begin
        w_texel_n   = {x, y};
        w_sub1      = w_flip ? y[1] : x[1];
        w_table_sel = w_sub1 ? w_table1 : w_table0;
        w_idx       = {w_idx_msbs[w_texel_n], w_idx_lsbs[w_texel_n]};
    end

    // ------------------------------------------------------------------
    // Base colours for both sub-blocks, per channel (0 = R, 1 = G, 2 = B)
    // ------------------------------------------------------------------
    logic [7:0] w_field   [NUM_CHANNELS];
    logic [7:0] w_base0   [NUM_CHANNELS];
    logic [7:0] w_base1   [NUM_CHANNELS];
    logic [7:0] w_base_ch [NUM_CHANNELS];

    // Expand each colour byte into the two sub-block bases for the active mode
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            logic [4:0] v_delta5;
            logic [4:0] v_sum5;

            w_field[c] = block[COLOR_R_MSB - COLOR_STRIDE * c -: 8];

            // Differential: 5-bit base plus sign-extended 3-bit delta; the
            // 5-bit add wraps mod 32, which is the defined result for
            // out-of-range blocks.
            v_delta5 = {{2{w_field[c][2]}}, w_field[c][2:0]};
            v_sum5   = w_field[c][7:3] + v_delta5;

            if (w_diff) begin
                w_base0[c] = expand5(w_field[c][7:3]);
                w_base1[c] = expand5(v_sum5);
            end else begin
                w_base0[c] = expand4(w_field[c][7:4]);
                w_base1[c] = expand4(w_field[c][3:0]);
            end

            w_base_ch[c] = w_sub1 ? w_base1[c] : w_base0[c];
        end
    end

    // ------------------------------------------------------------------
    // Modifier: magnitude from the table, sign from idx[1]
    // ------------------------------------------------------------------
    logic [7:0]        w_mod_mag;
    logic signed [8:0] w_modifier;

    // Index 0/1 select +a/+b, 2/3 select -a/-b
    always_comb begin
        w_mod_mag  = MOD_TABLE[w_table_sel][w_idx[0]];
        w_modifier = $signed({1'b0, w_mod_mag});
        if (w_idx[1]) begin
            w_modifier = -$signed({1'b0, w_mod_mag});
        end
    end

    // ------------------------------------------------------------------
    // Channel add/clamp, one instance per colour channel
    // ------------------------------------------------------------------
    logic [7:0] w_out_ch [NUM_CHANNELS];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_channel
        etc1_channel u_channel (
            .i_base  (w_base_ch[c]),
            .i_mod   (w_modifier),
            .o_value (w_out_ch[c])
        );
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    rgb888_t pixel_d;
    rgb888_t pixel_q;

    // Assemble the decoded texel for capture
    always_comb begin
        pixel_d   = '0;
        pixel_d.r = w_out_ch[0];
        pixel_d.g = w_out_ch[1];
        pixel_d.b = w_out_ch[2];
    end

    // Single pipeline stage; reset clears the output without a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign pixel = pixel_q;

endmodule : etc1_decode
`default_nettype wire

// File: tb/tb_etc1_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_etc1_decode
// Brief    : Scoreboard bench for etc1_decode. Stimulus pushes expected
//            texels into a queue; a monitor pops one per clock after the
//            capturing edge and compares against the DUT output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_etc1_decode;

    logic        clk;
    logic        reset;
    logic [63:0] block;
    logic [1:0]  x;
    logic [1:0]  y;
    logic [23:0] pixel;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [23:0] exp_q  [$];
    string       name_q [$];

    int mod_a [8] = '{2, 5, 9, 13, 18, 24, 33, 47};
    int mod_b [8] = '{8, 17, 29, 42, 60, 80, 106, 183};

    etc1_decode u_dut (
        .clk   (clk),
        .reset (reset),
        .block (block),
        .x     (x),
        .y     (y),
        .pixel (pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode from the format rules, using plain integer arithmetic
    function automatic logic [23:0] ref_decode(input logic [63:0] b, input int xx, input int yy);
        int diff, flip, sub, tbl, n, idx, mag, m, fld, v0, v1, d, base, val;
        logic [23:0] res;
        diff = int'(b[33]);
        flip = int'(b[32]);
        sub  = flip ? (yy >= 2) : (xx >= 2);
        tbl  = sub ? int'((b >> 34) & 64'h7) : int'((b >> 37) & 64'h7);
        n    = xx * 4 + yy;
        idx  = 2 * int'(b[16 + n]) + int'(b[n]);
        mag  = (idx % 2 == 1) ? mod_b[tbl] : mod_a[tbl];
        m    = (idx >= 2) ? -mag : mag;
        res  = '0;
        for (int c = 0; c < 3; c++) begin
            fld = int'((b >> (56 - 8 * c)) & 64'hFF);
            if (diff == 0) begin
                base = sub ? (fld % 16) * 17 : (fld / 16) * 17;
            end else begin
                v0 = fld / 8;
                d  = fld % 8;
                if (d >= 4) d = d - 8;
                v1 = (v0 + d + 32) % 32;
                v0 = sub ? v1 : v0;
                base = v0 * 8 + v0 / 4;
            end
            val = base + m;
            if (val < 0)   val = 0;
            if (val > 255) val = 255;
            res = (res << 8) | 24'(val);
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one texel request and record the response the next edge must give
    task automatic apply(input logic [63:0] b, input int xx, input int yy,
                         input logic [23:0] exp, input string name);
        block = b;
        x     = 2'(xx);
        y     = 2'(yy);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic apply_model(input logic [63:0] b, input int xx, input int yy, input string name);
        apply(b, xx, yy, ref_decode(b, xx, yy), name);
    endtask

    // Monitor: one output per clock, sampled just after the capturing edge
    initial begin
        logic [23:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, pixel, e);
            end
        end
    end

    // Directed vectors with hand-derived results
    localparam int N_DIR = 8;
    logic [63:0] dir_blk [N_DIR] = '{
        64'h0123456789abcdef, 64'h0123456789abcdef,
        64'h0123456789abcdef, 64'h0123456789abcdef,
        64'hF0F0F00000000000, 64'hF0F0F00000000000,
        64'hF900000200000000, 64'hF900000200000000
    };
    int          dir_x   [N_DIR] = '{0, 1, 0, 3, 0, 2, 2, 0};
    int          dir_y   [N_DIR] = '{0, 0, 2, 3, 0, 0, 0, 0};
    logic [23:0] dir_exp [N_DIR] = '{
        24'h000018, 24'h0d2e4f, 24'h194a3a, 24'h002818,
        24'hffffff, 24'h020202, 24'h020202, 24'hff0202
    };
    string       dir_nm  [N_DIR] = '{
        "diff_low_clamp", "diff_plus_a", "diff_sub1_plus_b", "diff_sub1_minus_b",
        "indiv_high_clamp", "indiv_sub1", "diff_wrap_sub1", "diff_wrap_sub0"
    };

    initial begin
        logic [63:0] sb;

        reset = 1'b0;
        block = '0;
        x     = '0;
        y     = '0;

        // Output is cleared before any clock edge and stays clear in reset
        #3;
        check("reset_initial", pixel, 24'h000000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", pixel, 24'h000000);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < N_DIR; i++) begin
            @(negedge clk);
            apply(dir_blk[i], dir_x[i], dir_y[i], dir_exp[i], dir_nm[i]);
        end

        // Raster scan of one random block with an asynchronous reset mid-way
        sb = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 9) reset = 1'b1;
            apply_model(sb, i % 4, i / 4, "scan");
            if (i == 8) begin
                @(posedge clk);
                #3;
                reset = 1'b0;
                #1;
                check("async_reset_now", pixel, 24'h000000);
                @(posedge clk);
                #2;
                check("async_reset_hold", pixel, 24'h000000);
            end
        end

        // Differential blocks with random deltas, including wrapping ones
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            sb = {$urandom, $urandom};
            sb[33] = 1'b1;
            apply_model(sb, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), "rand_diff");
        end

        // Fully random blocks and coordinates
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            sb = {$urandom, $urandom};
            apply_model(sb, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), "rand");
        end

        // Let the last response drain, then confirm none went unchecked
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 24'(exp_q.size()), 24'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_etc1_decode
`default_nettype wire
